// File: rtl/ultrasonic_distance_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : ultrasonic_distance_filter_if
// Brief    : Sample stream, control and result bundle for the distance filter.
// Revision : 1.0
// ============================================================================
interface ultrasonic_distance_filter_if;
  logic [8:0] dist_in;
  logic       dist_valid;
  logic       clear;
  logic [8:0] threshold;
  logic [3:0] hyst;
  logic [8:0] avg_dist;
  logic       avg_valid;
  logic       near_alarm;
  logic [8:0] min_dist;
  logic [8:0] max_dist;
  logic [7:0] reject_cnt;

  modport master (
    output dist_in, dist_valid, clear, threshold, hyst,
    input  avg_dist, avg_valid, near_alarm, min_dist, max_dist, reject_cnt
  );

  modport slave (
    input  dist_in, dist_valid, clear, threshold, hyst,
    output avg_dist, avg_valid, near_alarm, min_dist, max_dist, reject_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ultrasonic_distance_filter.sv
`default_nettype none
// ============================================================================
// Module   : ultrasonic_distance_filter
// Brief    : Range-checks raw ranging samples; moving average, min/max and a
//            hysteretic near-object alarm.
// Revision : 1.0
// ============================================================================
module ultrasonic_distance_filter #(
  parameter int DEPTH  = 4,
  parameter int MAX_CM = 400
) (
  input wire                          PCLK,
  input wire                          PRESETn,
  ultrasonic_distance_filter_if.slave bus
);

  localparam int         LOG2_DEPTH = $clog2(DEPTH);
  localparam int         c_sum_w    = 9 + LOG2_DEPTH;
  localparam logic [8:0] c_max_cm   = 9'(MAX_CM);
  localparam logic [8:0] c_min_init = 9'h1FF;

  typedef enum logic [0:0] {
    ST_FAR  = 1'b0,
    ST_NEAR = 1'b1
  } alarm_state_t;

  logic                  w_in_range;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_prime;
  logic [c_sum_w-1:0]    w_sample_ext;
  logic [c_sum_w-1:0]    w_old_ext;
  logic [c_sum_w-1:0]    w_sum_upd;
  logic [c_sum_w-1:0]    w_sum_prime;
  logic [8:0]            w_new_avg;
  logic [9:0]            w_release_lvl;

  logic [8:0]            r_buf [DEPTH];
  logic [LOG2_DEPTH-1:0] r_wr_ptr;
  logic [c_sum_w-1:0]    r_sum;
  logic                  r_primed;
  logic                  r_upd;
  logic [8:0]            r_avg;
  logic                  r_avg_valid;
  logic [8:0]            r_min;
  logic [8:0]            r_max;
  logic [7:0]            r_rej;

  alarm_state_t          r_state;
  alarm_state_t          w_state_nxt;

  // clear has priority: a colliding sample is neither accepted nor rejected
  assign w_in_range = (bus.dist_in != 9'd0) && (bus.dist_in <= c_max_cm);
  assign w_accept   = bus.dist_valid && !bus.clear && w_in_range;
  assign w_reject   = bus.dist_valid && !bus.clear && !w_in_range;
  assign w_prime    = w_accept && !r_primed;

  assign w_sample_ext = {{LOG2_DEPTH{1'b0}}, bus.dist_in};
  assign w_old_ext    = {{LOG2_DEPTH{1'b0}}, r_buf[r_wr_ptr]};
  assign w_sum_upd    = r_sum - w_old_ext + w_sample_ext;
  assign w_sum_prime  = w_sample_ext << LOG2_DEPTH;

  assign w_new_avg     = r_sum[c_sum_w-1:LOG2_DEPTH];
  assign w_release_lvl = {1'b0, bus.threshold} + {6'd0, bus.hyst};

  // Window storage needs no reset: every entry is rewritten by the priming sample
  always_ff @(posedge PCLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_prime || (w_accept && (r_wr_ptr == LOG2_DEPTH'(i)))) begin
        r_buf[i] <= bus.dist_in;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_sum    <= '0;
      r_wr_ptr <= '0;
      r_primed <= 1'b0;
      r_min    <= c_min_init;
      r_max    <= 9'd0;
      r_rej    <= 8'd0;
      r_upd    <= 1'b0;
    end else if (bus.clear) begin
      r_sum    <= '0;
      r_wr_ptr <= '0;
      r_primed <= 1'b0;
      r_min    <= c_min_init;
      r_max    <= 9'd0;
      r_rej    <= 8'd0;
      r_upd    <= 1'b0;
    end else begin
      r_upd <= w_accept;
      if (w_reject && (r_rej != 8'hFF)) begin
        r_rej <= r_rej + 8'd1;
      end
      if (w_prime) begin
        r_sum    <= w_sum_prime;
        r_wr_ptr <= '0;
        r_primed <= 1'b1;
        r_min    <= bus.dist_in;
        r_max    <= bus.dist_in;
      end else if (w_accept) begin
        r_sum    <= w_sum_upd;
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (bus.dist_in < r_min) begin
          r_min <= bus.dist_in;
        end
        if (bus.dist_in > r_max) begin
          r_max <= bus.dist_in;
        end
      end
    end
  end

  // Output stage runs one cycle behind the window so it sees the settled sum
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_avg       <= 9'd0;
      r_avg_valid <= 1'b0;
    end else if (bus.clear) begin
      r_avg       <= 9'd0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= r_upd;
      if (r_upd) begin
        r_avg <= w_new_avg;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_FAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = ST_FAR;
    end else if (r_upd) begin
      case (r_state)
        ST_FAR: begin
          if (w_new_avg < bus.threshold) begin
            w_state_nxt = ST_NEAR;
          end
        end
        ST_NEAR: begin
          if ({1'b0, w_new_avg} >= w_release_lvl) begin
            w_state_nxt = ST_FAR;
          end
        end
        default: w_state_nxt = ST_FAR;
      endcase
    end
  end

  assign bus.avg_dist   = r_avg;
  assign bus.avg_valid  = r_avg_valid;
  assign bus.near_alarm = (r_state == ST_NEAR);
  assign bus.min_dist   = r_min;
  assign bus.max_dist   = r_max;
  assign bus.reject_cnt = r_rej;

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_distance_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ultrasonic_distance_filter
// Brief    : Directed self-checking bench for ultrasonic_distance_filter.
// Revision : 1.0
// ============================================================================
module tb_ultrasonic_distance_filter;

  logic PCLK;
  logic PRESETn;
  int   n_checks;
  int   n_errors;
  int   q_avg[$];
  int   q_alm[$];

  ultrasonic_distance_filter_if bus ();

  ultrasonic_distance_filter #(
    .DEPTH  (4),
    .MAX_CM (400)
  ) u_dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Record every result pulse together with the alarm level it carried
  always @(posedge PCLK) begin
    if (bus.avg_valid) begin
      q_avg.push_back(int'(bus.avg_dist));
      q_alm.push_back(int'(bus.near_alarm));
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  function automatic int avg_at(input int i);
    return (i < q_avg.size()) ? q_avg[i] : -1;
  endfunction

  function automatic int alm_at(input int i);
    return (i < q_alm.size()) ? q_alm[i] : -1;
  endfunction

  task automatic stream(input int vals[8], input int n);
    for (int i = 0; i < n; i++) begin
      bus.dist_in    = 9'(vals[i]);
      bus.dist_valid = 1'b1;
      tick();
    end
    bus.dist_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_avg"},   int'(bus.avg_dist),   0);
    check_val({tag, "_vld"},   int'(bus.avg_valid),  0);
    check_val({tag, "_alarm"}, int'(bus.near_alarm), 0);
    check_val({tag, "_min"},   int'(bus.min_dist),   511);
    check_val({tag, "_max"},   int'(bus.max_dist),   0);
    check_val({tag, "_rej"},   int'(bus.reject_cnt), 0);
  endtask

  initial begin
    int exp_avg[6];
    int exp_alm[5];
    n_checks = 0;
    n_errors = 0;
    PRESETn        = 1'b0;
    bus.dist_in    = 9'd0;
    bus.dist_valid = 1'b0;
    bus.clear      = 1'b0;
    bus.threshold  = 9'd50;
    bus.hyst       = 4'd5;
    repeat (3) tick();
    check_idle("reset");
    PRESETn = 1'b1;
    tick();

    // Priming: one sample fills the whole window
    stream('{100, 0, 0, 0, 0, 0, 0, 0}, 1);
    check_val("prime_vld_n1", int'(bus.avg_valid), 0);
    check_val("prime_min",    int'(bus.min_dist),  100);
    check_val("prime_max",    int'(bus.max_dist),  100);
    tick();
    check_val("prime_vld_n2", int'(bus.avg_valid),  1);
    check_val("prime_avg",    int'(bus.avg_dist),   100);
    check_val("prime_alarm",  int'(bus.near_alarm), 0);
    tick();
    check_val("prime_vld_n3", int'(bus.avg_valid), 0);

    // Back-to-back averaging across the pointer wrap
    stream('{200, 200, 200, 200, 40, 0, 0, 0}, 5);
    repeat (3) tick();
    exp_avg = '{100, 125, 150, 175, 200, 160};
    check_val("avg_pulses", q_avg.size(), 6);
    for (int i = 0; i < 6; i++) check_val($sformatf("avg_seq%0d", i), avg_at(i), exp_avg[i]);
    check_val("avg_min", int'(bus.min_dist), 40);
    check_val("avg_max", int'(bus.max_dist), 200);

    // Rejects interleaved with valid samples
    pulse_clear();
    check_idle("clear1");
    q_avg.delete();
    q_alm.delete();
    stream('{120, 0, 120, 401, 120, 511, 120, 0}, 7);
    repeat (3) tick();
    check_val("rej_cnt3",   int'(bus.reject_cnt), 3);
    check_val("rej_pulses", q_avg.size(), 4);
    for (int i = 0; i < 4; i++) check_val($sformatf("rej_avg%0d", i), avg_at(i), 120);
    check_val("rej_min", int'(bus.min_dist), 120);
    check_val("rej_max", int'(bus.max_dist), 120);
    bus.dist_in    = 9'd0;
    bus.dist_valid = 1'b1;
    repeat (300) tick();
    bus.dist_valid = 1'b0;
    repeat (2) tick();
    check_val("rej_sat",        int'(bus.reject_cnt), 255);
    check_val("rej_sat_pulses", q_avg.size(), 4);

    // Hysteresis: averages 60, 49, 52, 54, 55 against threshold 50 / hyst 5
    pulse_clear();
    q_avg.delete();
    q_alm.delete();
    stream('{60, 16, 72, 68, 64, 0, 0, 0}, 5);
    repeat (3) tick();
    exp_avg[0:4] = '{60, 49, 52, 54, 55};
    exp_alm      = '{0, 1, 1, 1, 0};
    check_val("hyst_pulses", q_avg.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("hyst_avg%0d", i),   avg_at(i), exp_avg[i]);
      check_val($sformatf("hyst_alarm%0d", i), alm_at(i), exp_alm[i]);
    end

    // Clear colliding with a sample while another is in the output stage
    stream('{0, 0, 0, 0, 0, 0, 0, 0}, 2);
    tick();
    check_val("coll_rej_pre", int'(bus.reject_cnt), 2);
    q_avg.delete();
    q_alm.delete();
    stream('{100, 0, 0, 0, 0, 0, 0, 0}, 1);
    bus.clear      = 1'b1;
    bus.dist_in    = 9'd80;
    bus.dist_valid = 1'b1;
    tick();
    bus.clear      = 1'b0;
    bus.dist_valid = 1'b0;
    check_idle("coll");
    repeat (3) tick();
    check_val("coll_no_pulse", q_avg.size(), 0);
    stream('{80, 0, 0, 0, 0, 0, 0, 0}, 1);
    repeat (3) tick();
    check_val("coll_prime_pulses", q_avg.size(), 1);
    check_val("coll_prime_avg", avg_at(0), 80);
    check_val("coll_prime_min", int'(bus.min_dist), 80);
    check_val("coll_prime_max", int'(bus.max_dist), 80);

    // Asynchronous reset between a sample and its result
    stream('{90, 0, 0, 0, 0, 0, 0, 0}, 1);
    #2;
    PRESETn = 1'b0;
    #1;
    check_idle("areset");
    q_avg.delete();
    q_alm.delete();
    tick();
    PRESETn = 1'b1;
    repeat (3) tick();
    check_val("areset_no_pulse", q_avg.size(), 0);
    stream('{30, 0, 0, 0, 0, 0, 0, 0}, 1);
    repeat (3) tick();
    check_val("areset_prime_pulses", q_avg.size(), 1);
    check_val("areset_prime_avg",   avg_at(0), 30);
    check_val("areset_prime_alarm", alm_at(0), 1);
    check_val("areset_alarm_level", int'(bus.near_alarm), 1);
    check_val("areset_prime_min",   int'(bus.min_dist), 30);
    check_val("areset_prime_max",   int'(bus.max_dist), 30);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
